// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and the gain-compensation multiplier for the vectoring CORDIC.
// All fixed-point constants assume the default 22-bit input width.
package cordic_pkg;

    localparam int CORDIC_MAX_ITER = 16;

    localparam logic [21:0] PI_Q420      = 22'd3294199;
    localparam logic [21:0] HALF_PI_Q420 = 22'd1647099;
    localparam logic [21:0] K_Q220       = 22'b0010011011011101001110;

    // pi in Q3.19 has the same integer value as pi/2 in Q4.20
    localparam int ANGLE_LIM_Q319 = int'(HALF_PI_Q420);

    localparam logic signed [23:0] ATAN_TABLE [0:CORDIC_MAX_ITER-1] = '{
        24'sd823550, 24'sd486170, 24'sd256879, 24'sd130396,
        24'sd65451,  24'sd32757,  24'sd16383,  24'sd8192,
        24'sd4096,   24'sd2048,   24'sd1024,   24'sd512,
        24'sd256,    24'sd128,    24'sd64,     24'sd32
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        COMP = 2'd3
    } state_t;

    // Exact x * K_Q220 built from shifted copies of x; x is non-negative here.
    function automatic logic [46:0] mul_k(input logic [24:0] x);
        logic [46:0] acc;
        acc = '0;
        for (int b = 0; b < 22; b++) begin
            if (K_Q220[b]) acc = acc + (47'(x) << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: drives y towards zero and accumulates the angle in z.
// Zero latency; no handshake, it sits between the iteration registers.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int XW  = 25,
    parameter int ZW  = 24,
    parameter int SHW = 4
) (
    input  logic signed [XW-1:0]  x,
    input  logic signed [XW-1:0]  y,
    input  logic signed [ZW-1:0]  z,
    input  logic        [SHW-1:0] shift,
    output logic signed [XW-1:0]  x_next,
    output logic signed [XW-1:0]  y_next,
    output logic signed [ZW-1:0]  z_next
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [ZW-1:0] step;

    assign x_sh = x >>> shift;
    assign y_sh = y >>> shift;
    assign step = ZW'(ATAN_TABLE[shift]);

    always_comb begin
        if (y[XW-1]) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - step;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + step;
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Vectoring CORDIC returning atan2(y,x) and magnitude; done 2+ITER/ITER_PER_CYCLE cycles after start (+1 with CORDIC_VEC_GAIN_COMP_EN).
// No backpressure: start is ignored while busy, results are held until the next done.
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int WIDTH          = 22,
    parameter int ITER           = 16,
    parameter int ITER_PER_CYCLE = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] angle_out,
    output logic        [WIDTH+1:0] mag_out
);

    localparam int XW   = WIDTH + 3;
    localparam int ZW   = WIDTH + 2;
    localparam int NCYC = ITER / ITER_PER_CYCLE;
    localparam int CW   = $clog2(NCYC + 1);
    localparam int SHW  = $clog2(ITER);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic signed [XW-1:0] x_r;
    logic signed [XW-1:0] y_r;
    logic signed [ZW-1:0] z_r;
    logic                 zero_r;

    logic signed [XW-1:0] xs  [0:ITER_PER_CYCLE];
    logic signed [XW-1:0] ys  [0:ITER_PER_CYCLE];
    logic signed [ZW-1:0] zs  [0:ITER_PER_CYCLE];
    logic [SHW-1:0]       idx [0:ITER_PER_CYCLE-1];

    assign xs[0] = x_r;
    assign ys[0] = y_r;
    assign zs[0] = z_r;

    for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_stage
        assign idx[k] = SHW'(32'(cnt) * ITER_PER_CYCLE + k);
        cordic_vec_stage #(.XW(XW), .ZW(ZW), .SHW(SHW)) u_stage (
            .x      (xs[k]),
            .y      (ys[k]),
            .z      (zs[k]),
            .shift  (idx[k]),
            .x_next (xs[k+1]),
            .y_next (ys[k+1]),
            .z_next (zs[k+1])
        );
    end

    // Round half-up Q4.20 -> Q3.19, then clamp to +/-pi so the angle never wraps.
    logic signed [ZW:0]      z_inc;
    logic signed [ZW-1:0]    z_half;
    logic signed [WIDTH-1:0] angle_n;

    assign z_inc  = (ZW+1)'(z_r) + (ZW+1)'(1);
    assign z_half = ZW'(z_inc >>> 1);

    always_comb begin
        angle_n = WIDTH'(z_half);
        if (zero_r)                         angle_n = '0;
        else if (z_half > ANGLE_LIM_Q319)   angle_n = WIDTH'(ANGLE_LIM_Q319);
        else if (z_half < -ANGLE_LIM_Q319)  angle_n = WIDTH'(-ANGLE_LIM_Q319);
    end

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic [WIDTH+1:0] mag_n;
    assign mag_n = (WIDTH+2)'(mul_k(x_r) >> 20);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            zero_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r    <= XW'(x_in);
                        y_r    <= XW'(y_in);
                        z_r    <= '0;
                        zero_r <= (x_in == '0) && (y_in == '0);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Left half-plane: rotate by pi so the iterations only see x >= 0.
                    if (x_r[XW-1]) begin
                        x_r <= -x_r;
                        y_r <= -y_r;
                        z_r <= y_r[XW-1] ? -ZW'(PI_Q420) : ZW'(PI_Q420);
                    end else begin
                        z_r <= '0;
                    end
                    state <= RUN;
                end
                RUN: begin
                    if (cnt == CW'(NCYC)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                        state <= COMP;
`else
                        angle_out <= angle_n;
                        mag_out   <= x_r[ZW-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`endif
                    end else begin
                        x_r <= xs[ITER_PER_CYCLE];
                        y_r <= ys[ITER_PER_CYCLE];
                        z_r <= zs[ITER_PER_CYCLE];
                        cnt <= cnt + CW'(1);
                    end
                end
                COMP: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    angle_out <= angle_n;
                    mag_out   <= mag_n;
                    done      <= 1'b1;
                    busy      <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed boundaries, randomized vectors, handshake and reset cases against a reference model.
module tb_cordic_vector;

    localparam int W = 22;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int LAT     = 7;
    localparam bit COMP_EN = 1'b1;
`else
    localparam int LAT     = 6;
    localparam bit COMP_EN = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                busy;
    logic                done;
    logic signed [W-1:0] angle_out;
    logic [W+1:0]        mag_out;

    int     ntests = 0;
    int     nfail  = 0;
    longint atan_q [16];
    real    gain;

    cordic_vector dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .angle_out (angle_out),
        .mag_out   (mag_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp, input longint tol);
        ntests++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Sequential CORDIC iterations on exact integers, straight from the algorithm definition.
    function automatic void ref_model(input logic signed [W-1:0] xv, input logic signed [W-1:0] yv,
                                      output longint ang, output longint mag);
        longint x, y, z, xn;
        x = xv;
        y = yv;
        z = 0;
        if (x < 0) begin
            z = (y >= 0) ? 3294199 : -3294199;
            x = -x;
            y = -y;
        end
        for (int i = 0; i < 16; i++) begin
            if (y < 0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atan_q[i];
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atan_q[i];
            end
            x = xn;
        end
        ang = (z + 1) >>> 1;
        if (ang > 1647099)  ang = 1647099;
        if (ang < -1647099) ang = -1647099;
        if (xv == 0 && yv == 0) ang = 0;
        mag = COMP_EN ? ((x * 636750) >>> 20) : x;
    endfunction

    task automatic launch(input logic signed [W-1:0] xv, input logic signed [W-1:0] yv, input bit hold);
        @(negedge clock);
        start = 1'b1;
        x_in  = xv;
        y_in  = yv;
        @(posedge clock);
        #1;
        check("accept_busy", busy, 1);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic verify(input string tag, input logic signed [W-1:0] xv, input logic signed [W-1:0] yv,
                          input int lat);
        longint ea, em, ra, rm;
        real    a, m;
        ref_model(xv, yv, ea, em);
        a  = $atan2(real'(yv), real'(xv)) * 524288.0;
        m  = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)) * gain;
        if (COMP_EN) m = m * 0.6072529350088814;
        ra = longint'($rtoi($floor(a + 0.5)));
        rm = longint'($rtoi($floor(m + 0.5)));
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_angle"}, angle_out, ea);
        check({tag, "_mag"}, mag_out, em);
        check_near({tag, "_angle_vs_atan2"}, angle_out, ra, 32);
        check_near({tag, "_mag_vs_hypot"}, mag_out, rm, 64);
    endtask

    task automatic run_case(input string tag, input logic signed [W-1:0] xv, input logic signed [W-1:0] yv);
        int lat;
        launch(xv, yv, 1'b0);
        wait_done(lat);
        verify(tag, xv, yv, lat);
        @(posedge clock);
        #1;
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [W-1:0] ax, ay, cx, cy;
        int                  lat, spur;
        real                 t, p;

        t = 1.0;
        p = 1.0;
        gain = 1.0;
        for (int i = 0; i < 16; i++) begin
            atan_q[i] = longint'($rtoi($floor($atan(t) * 1048576.0 + 0.5)));
            gain = gain * $sqrt(1.0 + p);
            t = t / 2.0;
            p = p / 4.0;
        end

        reset = 1'b0;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_angle", angle_out, 0);
        check("reset_mag", mag_out, 0);
        @(negedge clock);
        reset = 1'b1;

        run_case("x1_y0",      22'sh100000, 22'sh000000);
        run_case("x1_y1",      22'sh100000, 22'sh100000);
        run_case("xm1_y0",     22'sh300000, 22'sh000000);
        run_case("xm1_ym1lsb", 22'sh300000, 22'sh3FFFFF);
        run_case("x0_ym1",     22'sh000000, 22'sh300000);
        run_case("xm2_y0",     22'sh200000, 22'sh000000);
        run_case("x0_y0",      22'sh000000, 22'sh000000);

        for (int n = 0; n < 16; n++) begin
            ax = W'($urandom);
            ay = W'($urandom);
            run_case("random", ax, ay);
        end

        // start held high across two back-to-back runs, inputs changed right after each acceptance
        ax = W'($urandom);
        ay = W'($urandom);
        cx = W'($urandom);
        cy = W'($urandom);
        launch(ax, ay, 1'b1);
        x_in = cx;
        y_in = cy;
        wait_done(lat);
        verify("held_first", ax, ay, lat);
        @(posedge clock);
        #1;
        check("held_restart_busy", busy, 1);
        check("held_restart_no_done", done, 0);
        x_in = ax;
        y_in = ay;
        wait_done(lat);
        start = 1'b0;
        verify("held_second", cx, cy, lat);

        // reset in the middle of a run
        launch(22'sh0C0000, 22'sh350000, 1'b0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_angle", angle_out, 0);
        check("midrst_mag", mag_out, 0);
        @(negedge clock);
        reset = 1'b1;
        spur = 0;
        repeat (LAT + 4) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) spur++;
        end
        check("midrst_no_done", spur, 0);
        check("midrst_idle_busy", busy, 0);
        run_case("after_reset", 22'sh0C0000, 22'sh350000);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
